// File: rtl/hwpe_ctrl_package.sv
// Shared types and constants for the HWPE register file and its built-in
// March C- self-test engine.
package hwpe_ctrl_package;

    typedef enum logic [1:0] {
        BIST_IDLE = 2'd0,
        BIST_RUN  = 2'd1,
        BIST_GAP  = 2'd2,
        BIST_DONE = 2'd3
    } bist_state_e;

    typedef enum logic [2:0] {
        MARCH_E0 = 3'd0,
        MARCH_E1 = 3'd1,
        MARCH_E2 = 3'd2,
        MARCH_E3 = 3'd3,
        MARCH_E4 = 3'd4,
        MARCH_E5 = 3'd5
    } march_elem_e;

    localparam logic [1:0] BIST_MODE_SOLID   = 2'b00;
    localparam logic [1:0] BIST_MODE_CHECKER = 2'b01;
    localparam logic [1:0] BIST_MODE_BOTH    = 2'b10;

    // One byte of the data background; replicated across the word by the user.
    function automatic logic [7:0] bist_bg_byte(input logic use_checker);
        return use_checker ? 8'h55 : 8'h00;
    endfunction

endpackage

// File: rtl/hwpe_ctrl_regfile_latch.sv
// Register file storage: registered read (data valid the cycle after the
// request) and a write staging register, so a write lands one cycle later.
module hwpe_ctrl_regfile_latch #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    clear,
    input  logic                                    ReadEnable,
    input  logic [ADDR_WIDTH-1:0]                   ReadAddr,
    output logic [DATA_WIDTH-1:0]                   ReadData,
    input  logic                                    WriteEnable,
    input  logic [ADDR_WIDTH-1:0]                   WriteAddr,
    input  logic [DATA_WIDTH-1:0]                   WriteData,
    input  logic [DATA_WIDTH/8-1:0]                 WriteBE,
    output logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0]   MemContent
);
    localparam int unsigned N        = 2**ADDR_WIDTH;
    localparam int unsigned NUM_BYTE = DATA_WIDTH/8;

    logic [N-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
    logic                         we_q, we_d;
    logic [ADDR_WIDTH-1:0]        waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0]        wdata_q, wdata_d;
    logic [NUM_BYTE-1:0]          be_q, be_d;
    logic [DATA_WIDTH-1:0]        rdata_q, rdata_d;

    always_comb begin
        mem_d = mem_q;
        if (we_q) begin
            for (int b = 0; b < NUM_BYTE; b++) begin
                if (be_q[b]) mem_d[waddr_q][8*b +: 8] = wdata_q[8*b +: 8];
            end
        end
        we_d    = WriteEnable;
        waddr_d = WriteAddr;
        wdata_d = WriteData;
        be_d    = WriteBE;
        rdata_d = ReadEnable ? mem_q[ReadAddr] : rdata_q;
        if (clear) begin
            mem_d   = '0;
            we_d    = 1'b0;
            waddr_d = '0;
            wdata_d = '0;
            be_d    = '0;
            rdata_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
        end else begin
            mem_q   <= mem_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
        end
    end

    assign ReadData   = rdata_q;
    assign MemContent = mem_q;

endmodule

// File: rtl/hwpe_ctrl_regfile_march_engine.sv
// March C- sequencer: walks elements E0..E5 with a GAP cycle after each,
// compares read data one cycle after the read and keeps sticky status.
module hwpe_ctrl_regfile_march_engine
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  bist_start,
    input  logic [1:0]            bist_mode,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output bist_state_e           state_o,
    output logic                  fail_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o
);
    localparam int unsigned          NUM_BYTE  = DATA_WIDTH/8;
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    bist_state_e           state_q, state_d;
    march_elem_e           elem_q, elem_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wr_phase_q, wr_phase_d;
    logic                  checker_q, checker_d;
    logic                  both_q, both_d;
    logic                  second_q, second_d;
    logic                  cmp_valid_q, cmp_valid_d;
    logic [DATA_WIDTH-1:0] cmp_exp_q, cmp_exp_d;
    logic [ADDR_WIDTH-1:0] cmp_addr_q, cmp_addr_d;
    logic                  fail_q, fail_d;
    logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;

    logic [DATA_WIDTH-1:0] bg;
    logic has_rd, has_wr, rd_inv, wr_inv, descending, last_addr, do_rd, do_wr;

    always_comb begin
        bg         = {NUM_BYTE{bist_bg_byte(checker_q)}};
        has_rd     = (elem_q != MARCH_E0);
        has_wr     = (elem_q != MARCH_E5);
        rd_inv     = (elem_q == MARCH_E2) || (elem_q == MARCH_E4);
        wr_inv     = (elem_q == MARCH_E1) || (elem_q == MARCH_E3);
        descending = (elem_q == MARCH_E3) || (elem_q == MARCH_E4);
        last_addr  = descending ? (addr_q == '0) : (addr_q == ADDR_LAST);
        // A read/write element spends two cycles per address: read, then write.
        do_rd      = (state_q == BIST_RUN) && has_rd && !wr_phase_q;
        do_wr      = (state_q == BIST_RUN) && has_wr && (wr_phase_q || !has_rd);
    end

    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        addr_d      = addr_q;
        wr_phase_d  = wr_phase_q;
        checker_d   = checker_q;
        both_d      = both_q;
        second_d    = second_q;
        cmp_valid_d = 1'b0;
        cmp_exp_d   = cmp_exp_q;
        cmp_addr_d  = cmp_addr_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;

        if (cmp_valid_q && (rdata != cmp_exp_q)) begin
            fail_d = 1'b1;
            if (!fail_q) fail_addr_d = cmp_addr_q;
        end

        case (state_q)
            BIST_IDLE, BIST_DONE: begin
                if (bist_start) begin
                    state_d     = BIST_RUN;
                    elem_d      = MARCH_E0;
                    addr_d      = '0;
                    wr_phase_d  = 1'b0;
                    second_d    = 1'b0;
                    checker_d   = (bist_mode == BIST_MODE_CHECKER);
                    both_d      = (bist_mode == BIST_MODE_BOTH);
                    fail_d      = 1'b0;
                    fail_addr_d = '0;
                end
            end
            BIST_RUN: begin
                if (do_rd) begin
                    cmp_valid_d = 1'b1;
                    cmp_exp_d   = rd_inv ? ~bg : bg;
                    cmp_addr_d  = addr_q;
                end
                if (do_rd && has_wr) begin
                    wr_phase_d = 1'b1;
                end else begin
                    wr_phase_d = 1'b0;
                    if (last_addr) state_d = BIST_GAP;
                    else addr_d = descending ? addr_q - ADDR_ONE : addr_q + ADDR_ONE;
                end
            end
            BIST_GAP: begin
                state_d = BIST_RUN;
                case (elem_q)
                    MARCH_E0: begin elem_d = MARCH_E1; addr_d = '0;        end
                    MARCH_E1: begin elem_d = MARCH_E2; addr_d = '0;        end
                    MARCH_E2: begin elem_d = MARCH_E3; addr_d = ADDR_LAST; end
                    MARCH_E3: begin elem_d = MARCH_E4; addr_d = ADDR_LAST; end
                    MARCH_E4: begin elem_d = MARCH_E5; addr_d = '0;        end
                    default: begin
                        addr_d = '0;
                        elem_d = MARCH_E0;
                        // Mode 10 reruns the whole march on the checkerboard background.
                        if (both_q && !second_q) begin
                            second_d  = 1'b1;
                            checker_d = 1'b1;
                        end else begin
                            state_d = BIST_DONE;
                        end
                    end
                endcase
            end
            default: state_d = BIST_IDLE;
        endcase

        if (clear) begin
            state_d     = BIST_IDLE;
            elem_d      = MARCH_E0;
            addr_d      = '0;
            wr_phase_d  = 1'b0;
            checker_d   = 1'b0;
            both_d      = 1'b0;
            second_d    = 1'b0;
            cmp_valid_d = 1'b0;
            cmp_exp_d   = '0;
            cmp_addr_d  = '0;
            fail_d      = 1'b0;
            fail_addr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BIST_IDLE;
            elem_q      <= MARCH_E0;
            addr_q      <= '0;
            wr_phase_q  <= 1'b0;
            checker_q   <= 1'b0;
            both_q      <= 1'b0;
            second_q    <= 1'b0;
            cmp_valid_q <= 1'b0;
            cmp_exp_q   <= '0;
            cmp_addr_q  <= '0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            addr_q      <= addr_d;
            wr_phase_q  <= wr_phase_d;
            checker_q   <= checker_d;
            both_q      <= both_d;
            second_q    <= second_d;
            cmp_valid_q <= cmp_valid_d;
            cmp_exp_q   <= cmp_exp_d;
            cmp_addr_q  <= cmp_addr_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
        end
    end

    assign mem_re      = do_rd;
    assign mem_we      = do_wr;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wr_inv ? ~bg : bg;
    assign state_o     = state_q;
    assign fail_o      = fail_q;
    assign fail_addr_o = fail_addr_q;

endmodule

// File: rtl/hwpe_ctrl_regfile_bist.sv
// HWPE register file with self-sequencing March C- test: while the engine is
// busy it owns both storage ports and the functional ports are ignored.
module hwpe_ctrl_regfile_bist
    import hwpe_ctrl_package::*;
#(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  clear,
    input  logic                                  ReadEnable,
    input  logic [ADDR_WIDTH-1:0]                 ReadAddr,
    output logic [DATA_WIDTH-1:0]                 ReadData,
    input  logic                                  WriteEnable,
    input  logic [ADDR_WIDTH-1:0]                 WriteAddr,
    input  logic [DATA_WIDTH-1:0]                 WriteData,
    input  logic [DATA_WIDTH/8-1:0]               WriteBE,
    output logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0] MemContent,
    input  logic                                  bist_start,
    input  logic [1:0]                            bist_mode,
    output logic                                  bist_busy,
    output logic                                  bist_done,
    output logic                                  bist_fail,
    output logic [ADDR_WIDTH-1:0]                 bist_fail_addr
);
    localparam int unsigned NUM_BYTE = DATA_WIDTH/8;

    bist_state_e           eng_state;
    logic                  eng_re, eng_we;
    logic [ADDR_WIDTH-1:0] eng_addr;
    logic [DATA_WIDTH-1:0] eng_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  st_re, st_we;
    logic [ADDR_WIDTH-1:0] st_raddr, st_waddr;
    logic [DATA_WIDTH-1:0] st_wdata;
    logic [NUM_BYTE-1:0]   st_be;

    hwpe_ctrl_regfile_march_engine #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_engine (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .bist_start  (bist_start),
        .bist_mode   (bist_mode),
        .rdata       (mem_rdata),
        .mem_re      (eng_re),
        .mem_we      (eng_we),
        .mem_addr    (eng_addr),
        .mem_wdata   (eng_wdata),
        .state_o     (eng_state),
        .fail_o      (bist_fail),
        .fail_addr_o (bist_fail_addr)
    );

    assign bist_busy = (eng_state == BIST_RUN) || (eng_state == BIST_GAP);
    assign bist_done = (eng_state == BIST_DONE);

    always_comb begin
        st_re    = bist_busy ? eng_re    : ReadEnable;
        st_raddr = bist_busy ? eng_addr  : ReadAddr;
        st_we    = bist_busy ? eng_we    : WriteEnable;
        st_waddr = bist_busy ? eng_addr  : WriteAddr;
        st_wdata = bist_busy ? eng_wdata : WriteData;
        st_be    = bist_busy ? '1        : WriteBE;
    end

    hwpe_ctrl_regfile_latch #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_regfile (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .ReadEnable  (st_re),
        .ReadAddr    (st_raddr),
        .ReadData    (mem_rdata),
        .WriteEnable (st_we),
        .WriteAddr   (st_waddr),
        .WriteData   (st_wdata),
        .WriteBE     (st_be),
        .MemContent  (MemContent)
    );

    assign ReadData = mem_rdata;

endmodule

// File: tb/tb_hwpe_ctrl_regfile_bist.sv
// Bench for hwpe_ctrl_regfile_bist: functional port against an array model,
// BIST duration/status/contents against figures derived from the March C- rules.
module tb_hwpe_ctrl_regfile_bist;
    localparam int AW       = 5;
    localparam int DW       = 32;
    localparam int N        = 32;
    localparam int NB       = 4;
    localparam int PASS_LEN = 10*N + 6;
    localparam int NONE     = -10;

    logic          clk = 1'b0;
    logic          rst_n, clear;
    logic          ReadEnable, WriteEnable;
    logic [AW-1:0] ReadAddr, WriteAddr;
    logic [DW-1:0] ReadData, WriteData;
    logic [NB-1:0] WriteBE;
    logic [N*DW-1:0] MemContent;
    logic          bist_start;
    logic [1:0]    bist_mode;
    logic          bist_busy, bist_done, bist_fail;
    logic [AW-1:0] bist_fail_addr;

    hwpe_ctrl_regfile_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk), .rst_n (rst_n), .clear (clear),
        .ReadEnable (ReadEnable), .ReadAddr (ReadAddr), .ReadData (ReadData),
        .WriteEnable (WriteEnable), .WriteAddr (WriteAddr), .WriteData (WriteData),
        .WriteBE (WriteBE), .MemContent (MemContent),
        .bist_start (bist_start), .bist_mode (bist_mode), .bist_busy (bist_busy),
        .bist_done (bist_done), .bist_fail (bist_fail), .bist_fail_addr (bist_fail_addr)
    );

    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] model_mem [N];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] force_val;

    // ---------------- reference model ----------------
    function automatic logic [DW-1:0] merge_be(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                               input logic [NB-1:0] be);
        logic [DW-1:0] r;
        r = old_w;
        for (int b = 0; b < NB; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    function automatic logic [DW-1:0] final_bg(input logic [1:0] mode);
        return (mode == 2'b01 || mode == 2'b10) ? 32'h5555_5555 : 32'h0000_0000;
    endfunction

    // Cycle (0 = first busy cycle) in which the read of address a in element e is compared.
    function automatic int cmp_cycle(input int e, input int a);
        int rd;
        case (e)
            1:       rd = (N + 1)   + 2*a;
            2:       rd = (3*N + 2) + 2*a;
            3:       rd = (5*N + 3) + 2*(N-1-a);
            4:       rd = (7*N + 4) + 2*(N-1-a);
            default: rd = (9*N + 5) + a;
        endcase
        return rd + 1;
    endfunction

    // Value that read should return for background bg: E1/E3/E5 read B, E2/E4 read ~B.
    function automatic logic [DW-1:0] read_exp(input int e, input logic [DW-1:0] bg);
        return (e % 2 == 1) ? bg : ~bg;
    endfunction

    function automatic int mem_mismatches();
        int bad;
        bad = 0;
        for (int i = 0; i < N; i++) if (MemContent[i*DW +: DW] !== model_mem[i]) bad++;
        return bad;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        rst_n = 1'b0; clear = 1'b0; bist_start = 1'b0; bist_mode = 2'b00;
        ReadEnable = 1'b0; ReadAddr = '0; WriteEnable = 1'b0; WriteAddr = '0;
        WriteData = '0; WriteBE = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < N; i++) model_mem[i] = '0;
    endtask

    task automatic func_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
        WriteEnable = 1'b1; WriteAddr = a; WriteData = d; WriteBE = be;
        @(negedge clk);
        WriteEnable = 1'b0;
        @(negedge clk);
    endtask

    task automatic func_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
        ReadEnable = 1'b1; ReadAddr = a;
        @(negedge clk);
        d = ReadData;
        ReadEnable = 1'b0;
    endtask

    task automatic idle_inputs();
        ReadEnable = 1'b0; WriteEnable = 1'b0; bist_start = 1'b0; clear = 1'b0;
    endtask

    // Starts a test and counts busy cycles; optionally forces read data at up to two
    // compare cycles, pulses start/clear at given cycles and drives functional noise.
    task automatic run_bist(input logic [1:0] mode,
                            input int c0, input logic [DW-1:0] v0,
                            input int c1, input logic [DW-1:0] v1,
                            input int restart_cyc, input int clear_cyc, input bit noise,
                            output int cycles, output bit fail_seen);
        int k;
        fail_seen  = 1'b0;
        bist_mode  = mode;
        bist_start = 1'b1;
        @(negedge clk);
        bist_start = 1'b0;
        k = 0;
        while (bist_busy === 1'b1 && k < 3*PASS_LEN) begin
            if (k == c0 + 1 || k == c1 + 1) release dut.mem_rdata;
            if (k == c0) begin force_val = v0; force dut.mem_rdata = force_val; end
            if (k == c1) begin force_val = v1; force dut.mem_rdata = force_val; end
            if (bist_fail === 1'b1) fail_seen = 1'b1;
            bist_start = (k == restart_cyc);
            clear      = (k == clear_cyc);
            if (noise) begin
                WriteEnable = 1'($urandom_range(0, 1));
                WriteAddr   = AW'($urandom);
                WriteData   = $urandom;
                WriteBE     = NB'($urandom);
                ReadEnable  = 1'($urandom_range(0, 1));
                ReadAddr    = AW'($urandom);
                if (k == 5) begin
                    WriteEnable = 1'b1; WriteAddr = 5'd3; WriteData = 32'hDEAD_BEEF; WriteBE = 4'b0011;
                end
            end
            k++;
            @(negedge clk);
        end
        release dut.mem_rdata;
        idle_inputs();
        cycles = k;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        n_tests++; if (bist_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", bist_busy); end
        n_tests++; if (bist_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b exp 0", bist_done); end
        n_tests++; if (bist_fail !== 1'b0) begin n_fail++; $display("FAIL reset_fail: got %b exp 0", bist_fail); end
        n_tests++; if (bist_fail_addr !== '0) begin n_fail++; $display("FAIL reset_fail_addr: got %0d exp 0", bist_fail_addr); end
        n_tests++; if (ReadData !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h exp 0", ReadData); end
        n_tests++; if (mem_mismatches() != 0) begin n_fail++; $display("FAIL reset_mem: %0d words differ from 0", mem_mismatches()); end
    endtask

    task automatic test_random_rw(input int iters);
        logic [AW-1:0] a;
        logic [DW-1:0] d, got;
        logic [NB-1:0] be;
        for (int i = 0; i < iters; i++) begin
            a = AW'($urandom); d = $urandom; be = NB'($urandom);
            func_write(a, d, be);
            model_mem[a] = merge_be(model_mem[a], d, be);
            a = AW'($urandom);
            exp_q.push_back(model_mem[a]);
            func_read(a, got);
            n_tests++;
            if (got !== exp_q[0]) begin
                n_fail++; $display("FAIL func_rw addr %0d: got %h exp %h", a, got, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_mode_solid();
        int cyc; bit fs;
        logic [DW-1:0] got;
        logic [AW-1:0] a;
        run_bist(2'b00, NONE, '0, NONE, '0, -1, -1, 1'b1, cyc, fs);
        for (int i = 0; i < N; i++) model_mem[i] = final_bg(2'b00);
        n_tests++; if (cyc != PASS_LEN) begin n_fail++; $display("FAIL solid_len: got %0d exp %0d", cyc, PASS_LEN); end
        n_tests++; if (bist_done !== 1'b1) begin n_fail++; $display("FAIL solid_done: got %b exp 1", bist_done); end
        n_tests++; if (bist_fail !== 1'b0 || fs) begin n_fail++; $display("FAIL solid_fail: got %b exp 0", bist_fail); end
        n_tests++; if (mem_mismatches() != 0) begin n_fail++; $display("FAIL solid_mem: %0d words wrong", mem_mismatches()); end
        for (int i = 0; i < 4; i++) begin
            a = AW'($urandom);
            func_read(a, got);
            n_tests++; if (got !== model_mem[a]) begin n_fail++; $display("FAIL solid_read addr %0d: got %h exp %h", a, got, model_mem[a]); end
        end
        func_write(5'd3, 32'hDEAD_BEEF, 4'b0011);
        model_mem[3] = merge_be(model_mem[3], 32'hDEAD_BEEF, 4'b0011);
        func_read(5'd3, got);
        n_tests++; if (got !== model_mem[3]) begin n_fail++; $display("FAIL be_write: got %h exp %h", got, model_mem[3]); end
    endtask

    task automatic test_modes();
        logic [1:0] modes [3];
        int cyc, exp_len; bit fs;
        modes[0] = 2'b01; modes[1] = 2'b11; modes[2] = 2'b10;
        for (int m = 0; m < 3; m++) begin
            run_bist(modes[m], NONE, '0, NONE, '0, -1, -1, 1'b1, cyc, fs);
            exp_len = (modes[m] == 2'b10) ? 2*PASS_LEN : PASS_LEN;
            for (int i = 0; i < N; i++) model_mem[i] = final_bg(modes[m]);
            n_tests++; if (cyc != exp_len) begin n_fail++; $display("FAIL mode%b_len: got %0d exp %0d", modes[m], cyc, exp_len); end
            n_tests++; if (bist_done !== 1'b1 || bist_fail !== 1'b0) begin
                n_fail++; $display("FAIL mode%b_status: got done=%b fail=%b exp done=1 fail=0", modes[m], bist_done, bist_fail);
            end
            n_tests++; if (mem_mismatches() != 0) begin n_fail++; $display("FAIL mode%b_mem: %0d words wrong", modes[m], mem_mismatches()); end
        end
    endtask

    task automatic test_single_fault();
        int cyc, e, a; bit fs;
        for (int t = 0; t < 3; t++) begin
            e = (t == 0) ? 1 : $urandom_range(1, 5);
            a = (t == 0) ? 7 : $urandom_range(0, N-1);
            run_bist(2'b00, cmp_cycle(e, a), read_exp(e, 32'h0) ^ 32'h8, NONE, '0, -1, -1, 1'b0, cyc, fs);
            for (int i = 0; i < N; i++) model_mem[i] = final_bg(2'b00);
            n_tests++; if (cyc != PASS_LEN) begin n_fail++; $display("FAIL fault1_len E%0d a%0d: got %0d exp %0d", e, a, cyc, PASS_LEN); end
            n_tests++; if (bist_fail !== 1'b1 || bist_done !== 1'b1) begin
                n_fail++; $display("FAIL fault1_flag E%0d a%0d: got fail=%b done=%b exp 1 1", e, a, bist_fail, bist_done);
            end
            n_tests++; if (bist_fail_addr !== AW'(a)) begin n_fail++; $display("FAIL fault1_addr E%0d: got %0d exp %0d", e, bist_fail_addr, a); end
        end
    endtask

    task automatic test_two_faults();
        int cyc, e0, a0, e1, a1, exp_a; bit fs;
        for (int t = 0; t < 3; t++) begin
            if (t == 0) begin e0 = 1; a0 = 12; e1 = 2; a1 = 4; end
            else begin
                e0 = $urandom_range(1, 5); a0 = $urandom_range(0, N-1);
                do begin e1 = $urandom_range(1, 5); a1 = $urandom_range(0, N-1); end
                while (cmp_cycle(e1, a1) == cmp_cycle(e0, a0) || a1 == a0);
                if (cmp_cycle(e1, a1) < cmp_cycle(e0, a0)) begin
                    int te, ta; te = e0; ta = a0; e0 = e1; a0 = a1; e1 = te; a1 = ta;
                end
            end
            exp_a = a0;
            run_bist(2'b00, cmp_cycle(e0, a0), read_exp(e0, 32'h0) ^ 32'h8,
                     cmp_cycle(e1, a1), read_exp(e1, 32'h0) ^ 32'h8, -1, -1, 1'b0, cyc, fs);
            n_tests++; if (cyc != PASS_LEN || bist_fail !== 1'b1) begin
                n_fail++; $display("FAIL fault2_run: got len=%0d fail=%b exp len=%0d fail=1", cyc, bist_fail, PASS_LEN);
            end
            n_tests++; if (bist_fail_addr !== AW'(exp_a)) begin
                n_fail++; $display("FAIL fault2_addr: got %0d exp %0d (second fault at %0d)", bist_fail_addr, exp_a, a1);
            end
        end
    endtask

    task automatic test_clear_abort();
        int cyc; bit fs;
        run_bist(2'b00, cmp_cycle(1, 7), 32'h8, NONE, '0, -1, 100, 1'b0, cyc, fs);
        n_tests++; if (cyc != 101) begin n_fail++; $display("FAIL clear_len: got %0d exp 101", cyc); end
        n_tests++; if (!fs) begin n_fail++; $display("FAIL clear_prefail: got fail never seen exp seen before clear"); end
        n_tests++; if (bist_busy !== 1'b0 || bist_done !== 1'b0 || bist_fail !== 1'b0 || bist_fail_addr !== '0) begin
            n_fail++; $display("FAIL clear_status: got busy=%b done=%b fail=%b addr=%0d exp all 0",
                               bist_busy, bist_done, bist_fail, bist_fail_addr);
        end
        run_bist(2'b00, NONE, '0, NONE, '0, -1, -1, 1'b0, cyc, fs);
        for (int i = 0; i < N; i++) model_mem[i] = final_bg(2'b00);
        n_tests++; if (cyc != PASS_LEN || bist_done !== 1'b1 || bist_fail !== 1'b0) begin
            n_fail++; $display("FAIL clear_rerun: got len=%0d done=%b fail=%b exp %0d 1 0", cyc, bist_done, bist_fail, PASS_LEN);
        end
    endtask

    task automatic test_clear_start_collision();
        clear = 1'b1; bist_start = 1'b1; bist_mode = 2'b00;
        @(negedge clk);
        idle_inputs();
        n_tests++; if (bist_busy !== 1'b0 || bist_done !== 1'b0) begin
            n_fail++; $display("FAIL clear_vs_start: got busy=%b done=%b exp 0 0", bist_busy, bist_done);
        end
        @(negedge clk);
        n_tests++; if (bist_busy !== 1'b0) begin n_fail++; $display("FAIL clear_vs_start_late: got busy=%b exp 0", bist_busy); end
    endtask

    task automatic test_async_reset();
        bist_mode = 2'b01; bist_start = 1'b1;
        @(negedge clk);
        bist_start = 1'b0;
        repeat (60) @(negedge clk);
        n_tests++; if (bist_busy !== 1'b1) begin n_fail++; $display("FAIL arst_prebusy: got %b exp 1", bist_busy); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (bist_busy !== 1'b0 || bist_done !== 1'b0 || bist_fail !== 1'b0 || bist_fail_addr !== '0) begin
            n_fail++; $display("FAIL arst_status: got busy=%b done=%b fail=%b addr=%0d exp all 0",
                               bist_busy, bist_done, bist_fail, bist_fail_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int cyc; bit fs;
        run_bist(2'b00, cmp_cycle(3, 20), 32'hFFFF_FFF7, NONE, '0, -1, -1, 1'b0, cyc, fs);
        n_tests++; if (bist_fail !== 1'b1 || bist_fail_addr !== 5'd20) begin
            n_fail++; $display("FAIL b2b_first: got fail=%b addr=%0d exp 1 20", bist_fail, bist_fail_addr);
        end
        run_bist(2'b00, NONE, '0, NONE, '0, 50, -1, 1'b1, cyc, fs);
        for (int i = 0; i < N; i++) model_mem[i] = final_bg(2'b00);
        n_tests++; if (cyc != PASS_LEN) begin n_fail++; $display("FAIL b2b_len: got %0d exp %0d", cyc, PASS_LEN); end
        n_tests++; if (bist_done !== 1'b1 || bist_fail !== 1'b0 || bist_fail_addr !== '0) begin
            n_fail++; $display("FAIL b2b_status: got done=%b fail=%b addr=%0d exp 1 0 0", bist_done, bist_fail, bist_fail_addr);
        end
        n_tests++; if (mem_mismatches() != 0) begin n_fail++; $display("FAIL b2b_mem: %0d words wrong", mem_mismatches()); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_random_rw(24);
        test_mode_solid();
        test_modes();
        test_single_fault();
        test_two_faults();
        test_clear_abort();
        test_clear_start_collision();
        test_async_reset();
        test_back_to_back();
        test_random_rw(16);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hwpe_ctrl_regfile_bist.md
# hwpe_ctrl_regfile_bist

Latch-based HWPE register file with a built-in, self-sequencing March C- memory test engine. Replaces externally driven BIST pins with an internal FSM that generates addresses, data backgrounds and compares, and reports pass/fail plus the first failing address. Sits between the HWPE controller's register-file users and the `hwpe_ctrl_regfile_latch` storage array. Functional ports are ignored while a test runs.

## Interface
- `ADDR_WIDTH`, 5: address bits; depth N = 2**ADDR_WIDTH.
- `DATA_WIDTH`, 32: word width, multiple of 8; NUM_BYTE = DATA_WIDTH/8 (localparam).
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `clear` in 1: synchronous soft clear; aborts BIST, zeroes status, passed to storage.
- `ReadEnable` in 1, `ReadAddr` in ADDR_WIDTH, `ReadData` out DATA_WIDTH: functional read port.
- `WriteEnable` in 1, `WriteAddr` in ADDR_WIDTH, `WriteData` in DATA_WIDTH, `WriteBE` in NUM_BYTE: functional write port.
- `MemContent` out N*DATA_WIDTH: array contents, false path.
- `bist_start` in 1: one-cycle start pulse, honoured only in IDLE/DONE.
- `bist_mode` in 2: 00 solid (0/1s), 01 checkerboard (0x55../0xAA..), 10 solid then checkerboard, 11 reserved (treated as 00).
- `bist_busy` out 1: test in progress.
- `bist_done` out 1: level, set at end of test, cleared by next start or clear.
- `bist_fail` out 1: sticky mismatch flag.
- `bist_fail_addr` out ADDR_WIDTH: address of first mismatch.

## Operation
- Storage timing: read data valid one cycle after ReadEnable; a write accepted at cycle t is visible to reads issued at t+2 or later.
- Busy: engine owns both storage ports; functional inputs ignored; BIST writes use WriteBE all-ones. ReadData still reflects storage output.
- Background B, complement ~B. Pass = March C-: E0 ⇑(w B); E1 ⇑(r B, w ~B); E2 ⇑(r ~B, w B); E3 ⇓(r B, w ~B); E4 ⇓(r ~B, w B); E5 ⇑(r B).
- One op per cycle; r/w pairs on the same address occupy consecutive cycles. Compare is pipelined: expected data and address delayed one cycle, compared against ReadData.
- One GAP cycle after every element (no storage access) to meet write-to-read visibility across element boundaries and drain the last compare.
- FSM: IDLE → (start) RUN(E0..E5 with GAP) → if mode 10 and first pass, reload background, RUN again → DONE. DONE → (start) RUN. clear from any state → IDLE.
- Mismatch: set bist_fail; capture bist_fail_addr only on first mismatch of a test; test continues to completion.
- Start clears fail, fail_addr, done.

## Timing
- Reset / clear values: all outputs 0 (ReadData 0 until first read; MemContent per storage reset).
- Pass length: 10N + 6 cycles. bist_busy rises the cycle after bist_start; bist_done rises, bist_busy falls on the same edge, 10N+6 cycles later (2*(10N+6) for mode 10).
- Address counter wraps only between elements, never mid-element; descending elements start at N-1.
- bist_start while busy: ignored. Simultaneous clear and start: clear wins.
- rst_n mid-test: immediate return to IDLE, status 0; array contents undefined.

## Structure
- Shared `hwpe_ctrl_package`: state enum (IDLE, RUN, GAP, DONE), march element enum, BIST mode constants, checkerboard background constant generator.
- Sub-module `hwpe_ctrl_regfile_march_engine`: FSM, address/element counters, background select, compare pipeline, status regs. Top level: port mux plus `hwpe_ctrl_regfile_latch` instance.

## Test plan
- Reset, mode 00, N=32, fault-free: busy 1 for 326 cycles, done=1, fail=0; functional read of any address afterwards returns 0x00000000.
- Mode 10, N=32: done after 652 cycles, fail=0; last background leaves all words 0x55555555.
- Force ReadData bit 3 to 1 during E1 at address 7 only: fail=1, fail_addr=7, test still completes at cycle 326.
- Two injected mismatches (addr 12 then 4): fail_addr=12.
- clear at cycle 100 of a test: next cycle busy=0, done=0, fail=0; new start runs full 326 cycles.
- Functional write 0xDEADBEEF BE=4'b0011 to addr 3 while busy: ignored; after IDLE functional write/read of addr 3 with BE 0011 over 0 reads 0x0000BEEF.
